user_output_stretcher: RTL and testbench

USER_OUTPUT_STRETCHER -- requirements
Module: user_output_stretcher

---
 rtl/user_input_pkg.sv | 8 +
 rtl/stretch_timer.sv | 15 +
 rtl/user_output_stretcher.sv | 67 ++++++
 tb/tb_user_output_stretcher.sv | 76 +++++++
 4 files changed

// File: rtl/user_input_pkg.sv
// user_input_pkg: shared state encoding and default sizing for the output stretcher.
package user_input_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;
  localparam int HIGH_CYCLES_DEF = 4;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int MAX_PENDING_DEF = 3;
  localparam int TIMER_W = 8;
endpackage

// File: rtl/stretch_timer.sv
// stretch_timer: loadable down-counter that saturates at zero and flags done there.
module stretch_timer
  import user_input_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               done_o
);
  logic [TIMER_W-1:0] count_q, count_d;
  assign count_d = load_i ? value_i : (count_q != '0) ? count_q - TIMER_W'(1) : count_q;
  assign done_o = count_q == '0;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
endmodule

// File: rtl/user_output_stretcher.sv
// user_output_stretcher: turns single-cycle events into HIGH_CYCLES pulses separated by GAP_CYCLES.
// Define USER_OUTPUT_PENDING_EN to queue events arriving while busy instead of dropping them.
module user_output_stretcher
  import user_input_pkg::*;
#(
  parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic out,
  output logic busy,
  output logic dropped
);
  state_e state_q, state_d;
  logic out_q, busy_q, dropped_q, dropped_d;
  logic load, done, high_end, gap_end, replay;
  logic [TIMER_W-1:0] value;
  assign high_end = state_q == HIGH && done;
  assign gap_end = state_q == GAP && done;
`ifdef USER_OUTPUT_PENDING_EN
  localparam int PW = $clog2(MAX_PENDING + 1);
  logic [PW-1:0] pend_q, pend_d;
  logic full, queue_in;
  assign full = pend_q >= PW'(MAX_PENDING);
  // an event in the final GAP cycle is consumed by the replay itself, so it never overflows
  assign queue_in = in && state_q != IDLE && !gap_end;
  assign replay = gap_end && (pend_q != '0 || in);
  assign dropped_d = queue_in && full;
  assign pend_d = replay ? pend_q + PW'(in) - PW'(1) : (queue_in && !full) ? pend_q + PW'(1) : pend_q;
  always_ff @(posedge Clock) pend_q <= Reset ? '0 : pend_d;
`else
  localparam int unused_max_pending = MAX_PENDING;
  assign replay = 1'b0;
  assign dropped_d = in && state_q != IDLE;
`endif
  assign state_d = (state_q == IDLE && in) ? HIGH :
                   high_end ? GAP :
                   gap_end ? (replay ? HIGH : IDLE) : state_q;
  assign load = state_d != state_q;
  assign value = (state_d == GAP) ? TIMER_W'(GAP_CYCLES - 1) : TIMER_W'(HIGH_CYCLES - 1);
  stretch_timer u_timer (
    .clk(Clock),
    .rst(Reset),
    .load_i(load),
    .value_i(value),
    .done_o(done)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      out_q <= 1'b0;
      busy_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= state_d == HIGH;
      busy_q <= state_d != IDLE;
      dropped_q <= dropped_d;
    end
  end
  assign out = out_q;
  assign busy = busy_q;
  assign dropped = dropped_q;
endmodule

// File: tb/tb_user_output_stretcher.sv
// tb_user_output_stretcher: per-cycle vector tables for a default instance and a 1/1-cycle instance.
module tb_user_output_stretcher;
`ifdef USER_OUTPUT_PENDING_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct {
    bit    sel;
    bit    rst;
    bit    in;
    bit    out;
    bit    busy;
    bit    dropped;
    string name;
  } vec_t;
  vec_t vecs[$];
  logic clk = 1'b0;
  logic rst, in0, in1;
  logic out0, busy0, drop0, out1, busy1, drop1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  user_output_stretcher u_dflt (
    .Clock(clk), .Reset(rst), .in(in0), .out(out0), .busy(busy0), .dropped(drop0)
  );
  user_output_stretcher #(.HIGH_CYCLES(1), .GAP_CYCLES(1)) u_fast (
    .Clock(clk), .Reset(rst), .in(in1), .out(out1), .busy(busy1), .dropped(drop1)
  );
  // bit k of each mask describes row k of the sequence
  task automatic seq(input string name, input bit sel, input int n, input logic [31:0] r,
                     input logic [31:0] i, input logic [31:0] o, input logic [31:0] b,
                     input logic [31:0] d);
    for (int k = 0; k < n; k++) vecs.push_back('{sel, r[k], i[k], o[k], b[k], d[k], name});
  endtask
  task automatic chk(input string name, input string sig, input int row, input logic act,
                     input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s row %0d: got %b expected %b", name, sig, row, act, exp);
    end
  endtask
  initial begin
    int row;
    string last;
    rst = 1'b1;
    in0 = 1'b0;
    in1 = 1'b0;
    repeat (2) @(negedge clk);
    seq("reset", 0, 5, 'h3, 'h3, 0, 0, 0);
    seq("single", 0, 9, 0, 'h1, 'h1E, 'h7E, 0);
    seq("two", 0, 15, 0, 'h5, PEN ? 'h79E : 'h1E, PEN ? 'h1FFE : 'h7E, PEN ? 0 : 'h8);
    seq("held", 0, 27, 0, 'h3F, PEN ? 'h79E79E : 'h1E, PEN ? 'h1FFFFFE : 'h7E, PEN ? 'h60 : 'h7C);
    seq("gapend", 0, 21, 0, 'h45, PEN ? 'h1E79E : 'h1E, PEN ? 'h7FFFE : 'h7E, PEN ? 0 : 'h88);
    seq("midrst", 0, 12, 'h8, 'hF, 'hE, 'hE, PEN ? 0 : 'hC);
    seq("fast", 1, 11, 0, 'h55, PEN ? 'hAA : 'h22, PEN ? 'h1FE : 'h66, PEN ? 0 : 'h88);
    row = 0;
    last = "";
    foreach (vecs[j]) begin
      if (vecs[j].name != last) row = 0;
      last = vecs[j].name;
      @(negedge clk);
      chk(vecs[j].name, "out", row, vecs[j].sel ? out1 : out0, vecs[j].out);
      chk(vecs[j].name, "busy", row, vecs[j].sel ? busy1 : busy0, vecs[j].busy);
      chk(vecs[j].name, "dropped", row, vecs[j].sel ? drop1 : drop0, vecs[j].dropped);
      rst = vecs[j].rst;
      in0 = !vecs[j].sel && vecs[j].in;
      in1 = vecs[j].sel && vecs[j].in;
      row++;
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
